main_controller_fsm: RTL
========================

MAIN_CONTROLLER_FSM -- requirements
Module: main_controller_fsm

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; deasserts synchronously to clk.
REQ-004 Opcode  input  7  instruction bits [6:0], from the instruction register; valid from DECODE onward.
REQ-005 Zero  input  1  ALU zero flag; sampled in EXEC for branches.
REQ-006 imem_ack  input  1  instruction memory has returned the fetched word.
REQ-007 dmem_ack  input  1  data memory access complete.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 ALUOp  output  2  consumed by the ALU controller: 00 LW/SW/AUIPC/JALR, 01 Branch, 10 R-type/I-type, 11 JAL/LUI.
REQ-011 ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, IRWrite, PCWrite  outputs  1 each  datapath strobes.
REQ-012 illegal  output  1  sticky illegal-opcode flag.
REQ-013 retired  output  CNT_W  count of completed instructions.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP, decoded as Moore outputs from the state register and the opcode latched in DECODE.
REQ-015 FETCH: imem_req=1; stay in FETCH until imem_ack; on imem_ack, IRWrite=1 for exactly that cycle, then go to DECODE.
REQ-016 DECODE: latch Opcode into the opcode class; go to EXEC for a legal opcode, otherwise per REQ-027/028.
REQ-017 Legal opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-018 EXEC: ALUOp per REQ-010, held stable for the whole state; ALUSrc=1 for every class except R and B.
REQ-019 EXEC next state: LW/SW go to MEM; R, I, LUI, AUIPC, JAL, JALR go to WB; B goes to FETCH with PCWrite=Zero in that cycle.
REQ-020 MEM: dmem_req=1, with MemRead (LW) or MemWrite (SW) held until dmem_ack; on ack, LW goes to WB and SW goes to FETCH with PCWrite=1.
REQ-021 WB: RegWrite=1 and PCWrite=1 for one cycle; MemtoReg=1 only for LW; next state is FETCH.
REQ-022 retired SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, and wrap from all-ones to 0.
REQ-023 Zero-wait latencies (acks in the same cycle as the request): R/I/LUI/AUIPC/JAL/JALR take 4 cycles, LW 5, SW 4, B 3.
REQ-024 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-025 At most one of MemRead and MemWrite SHALL be 1 in any cycle; dmem_req=1 only in MEM.

Reset
REQ-026 When rst_n=0: state is FETCH; all strobes, imem_req, dmem_req, ALUOp and illegal are 0; retired is 0. An access in progress is abandoned. Fetch begins on the first clock edge after deassertion.

Configuration
REQ-027 With CTRL_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE goes to TRAP; TRAP sets illegal=1, holds every strobe and request at 0, and is left only by reset; retired does not count the instruction.
REQ-028 With CTRL_ILLEGAL_TRAP_EN undefined: an unknown opcode is a NOP; DECODE goes to FETCH with PCWrite=1 for one cycle, retired increments, illegal stays at 0, and the TRAP state does not exist.

Structure
REQ-029 Package ctrl_pkg SHALL hold the opcode localparams, the ALUOp encodings, the state enum and the opcode-class enum.
REQ-030 The combinational opcode-to-class mapping SHALL be the sub-module opcode_class_decode; the FSM, strobe decode and counter live in main_controller_fsm.

Verification
REQ-031 ADD (0110011), imem_ack and dmem_ack tied to 1 -> FETCH, DECODE, EXEC (ALUOp=10), WB (RegWrite=1, PCWrite=1); retired increments from 0 to 1.
REQ-032 LW with dmem_ack delayed 3 cycles -> MEM held 4 cycles with MemRead=1 and dmem_req=1, then WB with MemtoReg=1; 8 cycles total.
REQ-033 BEQ: Zero=1 gives PCWrite=1 in EXEC; Zero=0 gives PCWrite=0; both return to FETCH, with ALUOp=01 in EXEC.
REQ-034 Opcode 1111111: with the macro -> illegal=1 and no further imem_req until reset; without the macro -> PCWrite pulse, back to FETCH, illegal=0.
REQ-035 rst_n driven low mid-MEM of an SW -> MemWrite and dmem_req drop in the same cycle without a clock edge; after release, FETCH with retired=0.
REQ-036 CNT_W=4, 17 back-to-back LUI instructions -> retired wraps through 0 and reads 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the main controller: opcodes, ALUOp codes, state and opcode-class enums.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
package ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LW    = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_SW    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_B     = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNC   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_PASS   = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        , ST_TRAP = 3'd5
`endif
    } state_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LW      = 4'd2,
        CLS_SW      = 4'd3,
        CLS_B       = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } opclass_e;

    // ALU controller operation selected for each instruction class
    function automatic logic [ALUOP_W-1:0] alu_op_of(input opclass_e cls);
        case (cls)
            CLS_B:          alu_op_of = ALUOP_BRANCH;
            CLS_R, CLS_I:   alu_op_of = ALUOP_FUNC;
            CLS_JAL, CLS_LUI: alu_op_of = ALUOP_PASS;
            default:        alu_op_of = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/main_controller_fsm_if.sv
// Controller <-> datapath/memory handshake bundle; master is the controller side.
interface main_controller_fsm_if
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic [OPC_W-1:0]   Opcode;
    logic               Zero;
    logic               imem_ack;
    logic               dmem_ack;
    logic               imem_req;
    logic               dmem_req;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrc;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic               PCWrite;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  Opcode, Zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, ALUOp, ALUSrc, MemRead, MemWrite,
               RegWrite, MemtoReg, IRWrite, PCWrite, illegal, retired
    );

    modport slave (
        output Opcode, Zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, ALUOp, ALUSrc, MemRead, MemWrite,
               RegWrite, MemtoReg, IRWrite, PCWrite, illegal, retired
    );

endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode-to-class mapping; anything unrecognised is CLS_ILLEGAL.
module opcode_class_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output opclass_e         opclass_c
);

    // classify the raw opcode field
    always_comb begin
        opclass_c = CLS_ILLEGAL;
        case (opcode)
            OPC_R:     opclass_c = CLS_R;
            OPC_I:     opclass_c = CLS_I;
            OPC_LW:    opclass_c = CLS_LW;
            OPC_SW:    opclass_c = CLS_SW;
            OPC_B:     opclass_c = CLS_B;
            OPC_JAL:   opclass_c = CLS_JAL;
            OPC_JALR:  opclass_c = CLS_JALR;
            OPC_LUI:   opclass_c = CLS_LUI;
            OPC_AUIPC: opclass_c = CLS_AUIPC;
            default:   opclass_c = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/main_controller_fsm.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath strobe decode and retired-instruction counter.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes trap instead of acting as NOP).
module main_controller_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    main_controller_fsm_if.master bus
);

    state_e           state_q;
    state_e           state_d;
    opclass_e         cls_q;
    opclass_e         cls_dec_c;
    logic [CNT_W-1:0] retired_q;

    opcode_class_decode u_decode (
        .opcode    (bus.Opcode),
        .opclass_c (cls_dec_c)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // capture the instruction class while the opcode is first valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q <= CLS_ILLEGAL;
        end else if (state_q == ST_DECODE) begin
            cls_q <= cls_dec_c;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls_dec_c == CLS_ILLEGAL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    CLS_B:          state_d = ST_FETCH;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack) state_d = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // count every instruction that completes back into FETCH (a trap never returns)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.retired = retired_q;

    // strobe decode; everything is forced low while reset is held
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.ALUOp    = ALUOP_ADD;
        bus.ALUSrc   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.illegal  = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.IRWrite  = bus.imem_ack;
                end
                ST_DECODE: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
                    bus.PCWrite = (cls_dec_c == CLS_ILLEGAL);
`endif
                end
                ST_EXEC: begin
                    bus.ALUOp  = alu_op_of(cls_q);
                    bus.ALUSrc = (cls_q != CLS_R) && (cls_q != CLS_B);
                    if (cls_q == CLS_B) bus.PCWrite = bus.Zero;
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.MemRead  = (cls_q == CLS_LW);
                    bus.MemWrite = (cls_q == CLS_SW);
                    bus.PCWrite  = (cls_q == CLS_SW) && bus.dmem_ack;
                end
                ST_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                    bus.MemtoReg = (cls_q == CLS_LW);
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    bus.illegal = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
